// File: rtl/sample_feeder.sv
// Sample feeder: buffers host samples in a small FIFO and streams one frame
// of samples per query into the accelerator, then waits for and captures the
// accelerator's class result.
module sample_feeder #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 6,
    parameter int LEN_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // host sample stream
    input  logic                       s_valid_i,
    input  logic [DATA_W-1:0]          s_data_i,
    output logic                       s_ready_o,
    // query control
    input  logic [LEN_W-1:0]           frame_len_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    // accelerator sample interface
    output logic                       in_valid_o,
    output logic [DATA_W-1:0]          in_value_o,
    input  logic                       in_ready_i,
    output logic                       input_done_o,
    // accelerator result interface
    input  logic                       output_valid_i,
    input  logic [4:0]                 class_i,
    output logic                       result_valid_o,
    output logic [4:0]                 result_class_o,
    // status
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       cfg_err_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        DONE     = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    state_t              state_q;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [LVL_W-1:0]    level_q;

    // frame bookkeeping
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;

    // result / status registers
    logic                cfg_err_q;
    logic                res_vld_q;
    logic [4:0]          res_class_q;

    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                last_sample;

    assign fifo_empty  = (level_q == '0);
    assign s_ready_o   = (level_q < LVL_W'(DEPTH));
    assign push        = s_valid_i && s_ready_o;
    assign in_valid_o  = (state_q == STREAM) && !fifo_empty;
    assign pop         = in_valid_o && in_ready_i;
    assign last_sample = (cnt_q == (len_q - LEN_W'(1)));

    // The head entry is presented directly; it is only meaningful while in_valid_o.
    assign in_value_o     = mem[rd_ptr_q];
    assign fifo_level_o   = level_q;
    assign busy_o         = (state_q != IDLE);
    // An abort in the same cycle squashes any pulse that would otherwise be seen.
    assign input_done_o   = (state_q == DONE) && !abort_i;
    assign result_valid_o = res_vld_q && !abort_i;
    assign result_class_o = res_class_q;
    assign cfg_err_o      = cfg_err_q;

    // FIFO storage write; contents need no reset since occupancy is tracked separately
    always_ff @(posedge clk_i) begin
        if (push && !abort_i && !rst_i) begin
            mem[wr_ptr_q] <= s_data_i;
        end
    end

    // FIFO pointers and occupancy; abort flushes by collapsing both pointers
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Query sequencer: frame streaming, end-of-frame pulse, result capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_err_q   <= 1'b0;
            res_vld_q   <= 1'b0;
            res_class_q <= '0;
        end else begin
            res_vld_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (frame_len_i == '0) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                cfg_err_q <= 1'b0;
                                len_q     <= frame_len_i;
                                cnt_q     <= '0;
                                state_q   <= STREAM;
                            end
                        end
                    end
                    STREAM: begin
                        if (pop) begin
                            if (last_sample) begin
                                cnt_q   <= '0;
                                state_q <= DONE;
                            end else begin
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        state_q <= WAIT_RES;
                    end
                    WAIT_RES: begin
                        if (output_valid_i) begin
                            res_class_q <= class_i;
                            res_vld_q   <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
